// File: rtl/psum_pkg.sv
// Shared width, default depth and FSM state encodings for the GLB psum bank.
package psum_pkg;
  localparam int PSUM_W    = 21;
  localparam int DEPTH_DEF = 64;

  typedef enum logic [0:0] {
    WR_IDLE = 1'b0,
    WR_BUSY = 1'b1
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_t;
endpackage

// File: rtl/psum_glb_bank_if.sv
// Router-side psum streams of one GLB bank: PE->GLB write stream and GLB->PE replay stream.
interface psum_glb_bank_if;
  import psum_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic signed [PSUM_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [PSUM_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/psum_rd_skid.sv
// Two-entry output buffer for the read channel; bypasses when empty so a word
// read from memory can be handed off in the same cycle it arrives.
module psum_rd_skid
  import psum_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_vld,
  input  logic signed [PSUM_W-1:0] push_data,
  input  logic                     pop_rdy,
  output logic                     pop_vld,
  output logic signed [PSUM_W-1:0] pop_data,
  output logic [1:0]               occ
);
  logic [1:0]               cnt_p1;
  logic signed [PSUM_W-1:0] ent0_p1;
  logic signed [PSUM_W-1:0] ent1_p1;
  logic                     handoff;
  logic                     pop_fifo;
  logic                     push_fifo;

  assign pop_vld   = push_vld || (cnt_p1 != 2'd0);
  assign handoff   = pop_vld && pop_rdy;
  assign pop_fifo  = handoff && (cnt_p1 != 2'd0);
  // An arriving word is stored unless it bypasses straight to the consumer.
  assign push_fifo = push_vld && !(handoff && (cnt_p1 == 2'd0));
  assign pop_data  = !pop_vld ? '0 : ((cnt_p1 != 2'd0) ? ent0_p1 : push_data);
  assign occ       = cnt_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p1 <= 2'd0;
    end else if (push_fifo && !pop_fifo) begin
      cnt_p1 <= cnt_p1 + 2'd1;
    end else if (pop_fifo && !push_fifo) begin
      cnt_p1 <= cnt_p1 - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (pop_fifo) begin
      ent0_p1 <= (cnt_p1 == 2'd2) ? ent1_p1 : push_data;
    end else if (push_fifo) begin
      if (cnt_p1 == 2'd0) ent0_p1 <= push_data;
      else                ent1_p1 <= push_data;
    end
  end
endmodule

// File: rtl/psum_glb_bank.sv
// One GLB psum bank: descriptor-driven write sink and read replay channel.
// Optional PSUM_RELU_EN adds cfg_relu, clamping negative replayed words to zero.
module psum_glb_bank
  import psum_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_start,
  input  logic [AW-1:0] wr_base,
  input  logic [AW:0]   wr_len,
  output logic          wr_busy,
  output logic          wr_done,
  input  logic          rd_start,
  input  logic [AW-1:0] rd_base,
  input  logic [AW:0]   rd_len,
  output logic          rd_busy,
  output logic          rd_done,
`ifdef PSUM_RELU_EN
  input  logic          cfg_relu,
`endif
  psum_glb_bank_if.slave bus
);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

  logic signed [PSUM_W-1:0] mem [DEPTH];

  wr_state_t     wr_state, wr_state_nx;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   wr_cnt;
  logic          wr_go, wr_fire, wr_last;

  rd_state_t     rd_state, rd_state_nx;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   rd_cnt;
  logic          rd_go, rd_issue, rd_last_issue, credit_ok, empty_nx;
  logic [2:0]    pending;

  logic                     vld_p0;
  logic signed [PSUM_W-1:0] rdata_p0;
  logic [1:0]               occ;
  logic                     skid_vld;
  logic signed [PSUM_W-1:0] skid_data;

  // ---------------- write channel ----------------
  assign wr_go   = wr_start && (wr_state == WR_IDLE);
  assign wr_fire = bus.in_valid && bus.in_ready;
  assign wr_last = wr_fire && (wr_cnt == CNT_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_state <= WR_IDLE;
    else        wr_state <= wr_state_nx;
  end

  always_comb begin
    wr_state_nx = wr_state;
    case (wr_state)
      WR_IDLE: if (wr_go && (wr_len != '0)) wr_state_nx = WR_BUSY;
      WR_BUSY: if (wr_last)                 wr_state_nx = WR_IDLE;
      default:                              wr_state_nx = WR_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (wr_state == WR_BUSY);
    wr_busy      = (wr_state == WR_BUSY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr <= '0;
      wr_cnt  <= '0;
      wr_done <= 1'b0;
    end else begin
      wr_done <= (wr_go && (wr_len == '0)) || wr_last;
      if (wr_go) begin
        wr_addr <= wr_base;
        wr_cnt  <= wr_len;
      end else if (wr_fire) begin
        wr_addr <= wr_addr + ADDR_ONE;
        wr_cnt  <= wr_cnt - CNT_ONE;
      end
    end
  end

  // Nonblocking write and read of the same address return the pre-write word.
  always_ff @(posedge clk) begin
    if (wr_fire)  mem[wr_addr] <= bus.in_data;
    if (rd_issue) rdata_p0     <= mem[rd_addr];
  end

  // ---------------- read channel ----------------
  assign rd_go         = rd_start && (rd_state == RD_IDLE);
  // Issue only if the buffer can absorb this word plus any word still in flight.
  assign credit_ok     = (occ == 2'd0) || ((occ == 2'd1) && !vld_p0);
  assign rd_issue      = (rd_state == RD_ISSUE) && credit_ok;
  assign rd_last_issue = rd_issue && (rd_cnt == CNT_ONE);
  assign pending       = {1'b0, occ} + {2'b00, vld_p0};
  assign empty_nx      = (pending == 3'd0) || ((pending == 3'd1) && skid_vld && bus.out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_state <= RD_IDLE;
    else        rd_state <= rd_state_nx;
  end

  always_comb begin
    rd_state_nx = rd_state;
    case (rd_state)
      RD_IDLE:  if (rd_go && (rd_len != '0)) rd_state_nx = RD_ISSUE;
      RD_ISSUE: if (rd_last_issue)           rd_state_nx = RD_DRAIN;
      RD_DRAIN: if (empty_nx)                rd_state_nx = RD_IDLE;
      default:                               rd_state_nx = RD_IDLE;
    endcase
  end

  always_comb begin
    rd_busy = (rd_state != RD_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
      rd_cnt  <= '0;
      rd_done <= 1'b0;
      vld_p0  <= 1'b0;
    end else begin
      rd_done <= (rd_go && (rd_len == '0)) || ((rd_state == RD_DRAIN) && empty_nx);
      vld_p0  <= rd_issue;
      if (rd_go) begin
        rd_addr <= rd_base;
        rd_cnt  <= rd_len;
      end else if (rd_issue) begin
        rd_addr <= rd_addr + ADDR_ONE;
        rd_cnt  <= rd_cnt - CNT_ONE;
      end
    end
  end

  // ---------------- output buffer ----------------
  psum_rd_skid u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_vld  (vld_p0),
    .push_data (rdata_p0),
    .pop_rdy   (bus.out_ready),
    .pop_vld   (skid_vld),
    .pop_data  (skid_data),
    .occ       (occ)
  );

  assign bus.out_valid = skid_vld;

`ifdef PSUM_RELU_EN
  logic relu_en;

  function automatic logic signed [PSUM_W-1:0] relu(input logic signed [PSUM_W-1:0] w);
    return w[PSUM_W-1] ? '0 : w;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     relu_en <= 1'b0;
    else if (rd_go) relu_en <= cfg_relu;
  end

  assign bus.out_data = relu_en ? relu(skid_data) : skid_data;
`else
  assign bus.out_data = skid_data;
`endif
endmodule

// File: tb/tb_psum_glb_bank.sv
// Directed bench for psum_glb_bank with a word-level memory/queue reference model.
`timescale 1ns/1ps
module tb_psum_glb_bank;
  import psum_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_start = 1'b0;
  logic [AW-1:0] wr_base = '0;
  logic [AW:0]   wr_len = '0;
  logic          wr_busy, wr_done;
  logic          rd_start = 1'b0;
  logic [AW-1:0] rd_base = '0;
  logic [AW:0]   rd_len = '0;
  logic          rd_busy, rd_done;
`ifdef PSUM_RELU_EN
  logic          cfg_relu = 1'b0;
`endif

  psum_glb_bank_if bif();

  psum_glb_bank #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_start (wr_start),
    .wr_base  (wr_base),
    .wr_len   (wr_len),
    .wr_busy  (wr_busy),
    .wr_done  (wr_done),
    .rd_start (rd_start),
    .rd_base  (rd_base),
    .rd_len   (rd_len),
    .rd_busy  (rd_busy),
    .rd_done  (rd_done),
`ifdef PSUM_RELU_EN
    .cfg_relu (cfg_relu),
`endif
    .bus      (bif)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic signed [PSUM_W-1:0] model_mem [DEPTH];
  logic signed [PSUM_W-1:0] wdat [16];
  logic signed [PSUM_W-1:0] exp_q [$];
  logic signed [PSUM_W-1:0] acc_log [$];

  bit  rd_active = 0;
  bit  done_seen = 0;
  int  n_acc = 0;
  int  last_acc_cyc = 0;
  int  first_vld_cyc = -1;
  int  start_cyc = 0;
  bit  stalled = 0;
  logic signed [PSUM_W-1:0] held;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output-stream checker: every handoff must be the next word the model predicts.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        chk("hold_valid", bif.out_valid, 1);
        chk("hold_data", bif.out_data, held);
      end
      if (bif.out_valid) begin
        if (first_vld_cyc < 0) first_vld_cyc = cyc;
        if (bif.out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL extra_word: got %0d, expected no word", bif.out_data);
          end else begin
            chk("rd_data", bif.out_data, exp_q.pop_front());
          end
          acc_log.push_back(bif.out_data);
          n_acc++;
          last_acc_cyc = cyc;
        end
      end
      stalled = bif.out_valid && !bif.out_ready;
      held    = bif.out_data;
      if (rd_done) begin
        if (!rd_active) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_rd_done: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          chk("rd_done_timing", cyc, last_acc_cyc + 1);
          chk("rd_words_left", exp_q.size(), 0);
          rd_active = 0;
          done_seen = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_burst(input int base, input int len);
    wr_start = 1'b1;
    wr_base  = AW'(base);
    wr_len   = (AW+1)'(len);
    tick();
    wr_start = 1'b0;
    for (int i = 0; i < len; i++) begin
      int guard = 0;
      bif.in_valid = 1'b1;
      bif.in_data  = wdat[i];
      @(negedge clk);
      while (!bif.in_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      chk("in_ready", bif.in_ready, 1);
      model_mem[(base + i) % DEPTH] = wdat[i];
      tick();
    end
    bif.in_valid = 1'b0;
    @(negedge clk);
    chk("wr_done", wr_done, 1);
    chk("wr_busy_after", wr_busy, 0);
    tick();
  endtask

  task automatic start_read(input int base, input int len, input bit relu);
    logic signed [PSUM_W-1:0] w;
    exp_q.delete();
    acc_log.delete();
    for (int i = 0; i < len; i++) begin
      w = model_mem[(base + i) % DEPTH];
      if (relu && w < 0) w = '0;
      exp_q.push_back(w);
    end
    n_acc         = 0;
    first_vld_cyc = -1;
    done_seen     = 0;
    rd_active     = 1;
    start_cyc     = cyc;
    last_acc_cyc  = cyc;
    rd_start      = 1'b1;
    rd_base       = AW'(base);
    rd_len        = (AW+1)'(len);
`ifdef PSUM_RELU_EN
    cfg_relu      = relu;
`endif
  endtask

  task automatic wait_rd(input int len, input bit toggle);
    int k = 0;
    while (!done_seen && k < 200) begin
      bif.out_ready = toggle ? (k % 2 == 0) : 1'b1;
      @(negedge clk);
      #1;
      if (!done_seen) tick();
      k++;
    end
    chk("rd_done_seen", done_seen, 1);
    chk("rd_count", n_acc, len);
    bif.out_ready = 1'b1;
    tick();
  endtask

  task automatic read_burst(input int base, input int len, input bit toggle, input bit relu);
    start_read(base, len, relu);
    tick();
    rd_start = 1'b0;
    wait_rd(len, toggle);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int k;
    bif.in_valid  = 1'b0;
    bif.in_data   = '0;
    bif.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_wr", {wr_busy, wr_done, bif.in_ready}, 0);
    chk("reset_rd", {rd_busy, rd_done, bif.out_valid}, 0);
    chk("reset_data", bif.out_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // basic write then replay
    wdat[0] = -3; wdat[1] = 7; wdat[2] = 0; wdat[3] = 1048575;
    write_burst(5, 4);
    read_burst(5, 4, 0, 0);
    chk("basic_w0", acc_log[0], -3);
    chk("basic_w1", acc_log[1], 7);
    chk("basic_w2", acc_log[2], 0);
    chk("basic_w3", acc_log[3], 1048575);
    chk("first_valid_lat", first_vld_cyc, start_cyc + 2);

    // address wrap
    wdat[0] = 100; wdat[1] = -200; wdat[2] = 300; wdat[3] = -400;
    write_burst(62, 4);
    read_burst(62, 4, 0, 0);
    read_burst(0, 2, 0, 0);
    chk("wrap_addr0", acc_log[0], 300);
    chk("wrap_addr1", acc_log[1], -400);

    // backpressure with out_ready toggling
    for (int i = 0; i < 8; i++) wdat[i] = PSUM_W'(i * 1000 - 3500);
    write_burst(20, 8);
    read_burst(20, 8, 1, 0);
    chk("bp_w7", acc_log[7], 3500);

    // same-cycle write and read of address 10
    wdat[0] = 111;
    write_burst(10, 1);
    start_read(10, 1, 0);
    wr_start = 1'b1; wr_base = AW'(10); wr_len = (AW+1)'(1);
    bif.in_valid = 1'b1; bif.in_data = 222;
    tick();
    wr_start = 1'b0; rd_start = 1'b0;
    @(negedge clk);
    chk("conc_in_ready", bif.in_ready, 1);
    tick();
    bif.in_valid = 1'b0;
    model_mem[10] = 222;
    @(negedge clk);
    chk("conc_wr_done", wr_done, 1);
    tick();
    wait_rd(1, 0);
    chk("conc_old", acc_log[0], 111);
    read_burst(10, 1, 0, 0);
    chk("conc_new", acc_log[0], 222);

    // zero-length descriptors on both channels
    start_read(0, 0, 0);
    wr_start = 1'b1; wr_base = '0; wr_len = '0;
    tick();
    wr_start = 1'b0; rd_start = 1'b0;
    @(negedge clk);
    chk("len0_wr_done", wr_done, 1);
    chk("len0_rd_done", rd_done, 1);
    chk("len0_busy", {wr_busy, rd_busy}, 0);
    chk("len0_in_ready", bif.in_ready, 0);
    tick();
    @(negedge clk);
    chk("len0_done_clear", {wr_done, rd_done}, 0);
    chk("len0_in_ready2", bif.in_ready, 0);
    chk("len0_no_valid", first_vld_cyc, -1);
    tick();

    // reset in the middle of a read
    for (int i = 0; i < 6; i++) wdat[i] = PSUM_W'(-(i + 1) * 11);
    write_burst(40, 6);
    start_read(40, 6, 0);
    tick();
    rd_start = 1'b0;
    k = 0;
    while (n_acc < 3 && k < 50) begin
      @(negedge clk);
      #1;
      if (n_acc < 3) tick();
      k++;
    end
    chk("rst_pre_acc", n_acc, 3);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_outs", {bif.out_valid, bif.in_ready, rd_busy, rd_done, wr_busy, wr_done}, 0);
    chk("rst_out_data", bif.out_data, 0);
    exp_q.delete();
    rd_active = 0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("rst_after_busy", rd_busy, 0);
    for (int i = 0; i < 6; i++) wdat[i] = PSUM_W'(i * 7 + 1);
    write_burst(40, 6);
    read_burst(40, 6, 0, 0);
    chk("rst_fresh_w5", acc_log[5], 36);

`ifdef PSUM_RELU_EN
    wdat[0] = -5; wdat[1] = 9;
    write_burst(30, 2);
    read_burst(30, 2, 0, 1);
    chk("relu_on_w0", acc_log[0], 0);
    chk("relu_on_w1", acc_log[1], 9);
    read_burst(30, 2, 0, 0);
    chk("relu_off_w0", acc_log[0], -5);
    chk("relu_off_w1", acc_log[1], 9);
`endif

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
